// File: rtl/nand_seq_pkg.sv
// Shared constants for the NAND page sequencer: frame opcodes, NAND
// command bytes, status codes, RAM frame offsets and FSM state codes.
package nand_seq_pkg;

    // Frame opcodes (ASCII, as typed on the UART)
    localparam logic [7:0] OP_READ = 8'h52;
    localparam logic [7:0] OP_ID   = 8'h49;

    // NAND command bytes
    localparam logic [7:0] NAND_READ1 = 8'h00;
    localparam logic [7:0] NAND_READ2 = 8'h30;
    localparam logic [7:0] NAND_RDID  = 8'h90;

    // Status byte values written back into the frame
    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_BADOP   = 8'h01;
    localparam logic [7:0] ST_TIMEOUT = 8'h02;

    // Frame layout offsets inside the command RAM
    localparam int unsigned OFS_OP   = 0;
    localparam int unsigned OFS_ADDR = 1;
    localparam int unsigned OFS_STAT = 6;
    localparam int unsigned OFS_DATA = 8;

    // FSM state codes
    localparam int         STATE_W  = 4;
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_CMD1   = 4'd2;
    localparam logic [3:0] S_ADDR   = 4'd3;
    localparam logic [3:0] S_CMD2   = 4'd4;
    localparam logic [3:0] S_WAIT   = 4'd5;
    localparam logic [3:0] S_READ   = 4'd6;
    localparam logic [3:0] S_STATUS = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;

    // True for the opcodes this block knows how to execute
    function automatic logic op_valid(input logic [7:0] op);
        return (op == OP_READ) || (op == OP_ID);
    endfunction

endpackage

// File: rtl/nand_strobe_timer.sv
// One active-low strobe pulse: T_PULSE cycles low then T_PULSE cycles high.
// A go pulse starts a new strobe in the next cycle; go may be issued in the
// last cycle of a running pulse so strobes can be chained back to back.
module nand_strobe_timer #(
    parameter int T_PULSE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    output logic strobe_n,
    output logic sample,
    output logic rise_edge,
    output logic last,
    output logic busy
);

    localparam int CW = $clog2(2 * T_PULSE + 1);
    localparam logic [CW-1:0] LOW_LAST = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] RISE_CNT = CW'(T_PULSE);
    localparam logic [CW-1:0] END_CNT  = CW'(2 * T_PULSE - 1);

    logic          active;
    logic [CW-1:0] cnt;

    // Phase counter: runs 0..2*T_PULSE-1 while a strobe is in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (go) begin
            active <= 1'b1;
            cnt    <= '0;
        end else if (active) begin
            if (cnt == END_CNT) begin
                active <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign busy      = active;
    assign strobe_n  = !(active && (cnt <= LOW_LAST));
    assign sample    = active && (cnt == LOW_LAST);
    assign rise_edge = active && (cnt == RISE_CNT);
    assign last      = active && (cnt == END_CNT);

endmodule

// File: rtl/nand_page_sequencer.sv
// Executes one command frame from the shared command RAM on the NAND bus
// (page read or read-ID) and writes status plus data back into the frame.
module nand_page_sequencer
    import nand_seq_pkg::*;
#(
    parameter int T_PULSE    = 4,
    parameter int T_WB       = 16,
    parameter int RB_TIMEOUT = 1000000,
    parameter int PAGE_BYTES = 2112,
    parameter int ADDR_W     = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                done,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_r_e,
    output logic                ram_w_e,
    output logic [7:0]          ram_wdata,
    input  logic [7:0]          ram_rdata,
    output logic                ce,
    output logic                we,
    output logic                re,
    output logic                cle,
    output logic                ale,
    input  logic                rb,
    input  logic [7:0]          io_in,
    output logic [7:0]          io_out,
    output logic                io_drive_en,
    output logic [STATE_W-1:0]  state_dbg
);

    localparam int WMAX = (RB_TIMEOUT > T_WB) ? RB_TIMEOUT : T_WB;
    localparam int WW   = $clog2(WMAX + 1);
    localparam logic [WW-1:0] TWB_LAST = WW'(T_WB - 1);
    localparam logic [WW-1:0] TO_LAST  = WW'(RB_TIMEOUT - 1);
    localparam logic [11:0]   PAGE_LAST = 12'(PAGE_BYTES - 1);

    logic [3:0]      state;
    logic [11:0]     cnt;        // FETCH index, address index, byte index, status index
    logic [7:0]      opcode;
    logic [4:0][7:0] addr_b;
    logic [7:0]      status;
    logic [7:0]      sample_q;
    logic            seen_low;
    logic [WW-1:0]   wcnt;

    logic            go;
    logic            strobe_n;
    logic            t_sample;
    logic            t_rise;
    logic            t_last;
    logic            t_busy;

    logic            is_r;
    logic [11:0]     addr_last;
    logic [11:0]     read_last;
    logic            wait_go;
    logic            wait_to;

    assign is_r      = (opcode == OP_READ);
    assign addr_last = is_r ? 12'd4 : 12'd0;
    assign read_last = is_r ? PAGE_LAST : 12'd4;
    assign state_dbg = state;

    // Leave WAIT_BUSY when rb is high after a low phase, or when rb never fell within T_WB
    assign wait_go = (state == S_WAIT) &&
                     ((seen_low && rb) || (!seen_low && rb && (wcnt == TWB_LAST)));
    assign wait_to = (state == S_WAIT) && seen_low && !rb && (wcnt == TO_LAST);

    nand_strobe_timer #(
        .T_PULSE (T_PULSE)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .strobe_n  (strobe_n),
        .sample    (t_sample),
        .rise_edge (t_rise),
        .last      (t_last),
        .busy      (t_busy)
    );

    // Strobe launch: first pulse on entering a bus phase, then chained on the last cycle
    always_comb begin
        go = 1'b0;
        case (state)
            S_FETCH: go = (cnt == 12'd6) && op_valid(opcode);
            S_CMD1:  go = t_last;
            S_ADDR:  go = t_last;
            S_WAIT:  go = wait_go;
            S_READ:  go = t_last && (cnt != read_last);
            default: go = 1'b0;
        endcase
    end

    // Main sequencer: frame fetch, NAND phases, status write-back, handshake with start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            opcode   <= '0;
            addr_b   <= '0;
            status   <= ST_OK;
            sample_q <= '0;
            seen_low <= 1'b0;
            wcnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_FETCH;
                        cnt    <= '0;
                        status <= ST_OK;
                    end
                end
                S_FETCH: begin
                    // Data for address i arrives in cycle i+1
                    if (cnt == 12'd1) begin
                        opcode <= ram_rdata;
                    end else if (cnt != 12'd0) begin
                        addr_b[cnt[2:0] - 3'd2] <= ram_rdata;
                    end
                    if (cnt == 12'd6) begin
                        cnt <= '0;
                        if (op_valid(opcode)) begin
                            state <= S_CMD1;
                        end else begin
                            status <= ST_BADOP;
                            state  <= S_STATUS;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_CMD1: begin
                    if (t_last) begin
                        state <= S_ADDR;
                        cnt   <= '0;
                    end
                end
                S_ADDR: begin
                    if (t_last) begin
                        if (cnt == addr_last) begin
                            state <= is_r ? S_CMD2 : S_READ;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_CMD2: begin
                    // Hold until the confirm strobe has fully completed
                    if (!t_busy) begin
                        state    <= S_WAIT;
                        wcnt     <= '0;
                        seen_low <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (wait_go) begin
                        state <= S_READ;
                        cnt   <= '0;
                    end else if (wait_to) begin
                        status <= ST_TIMEOUT;
                        state  <= S_STATUS;
                        cnt    <= '0;
                    end else if (!seen_low && !rb) begin
                        seen_low <= 1'b1;
                        wcnt     <= '0;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_READ: begin
                    if (t_sample) begin
                        sample_q <= io_in;
                    end
                    if (t_last) begin
                        if (cnt == read_last) begin
                            state <= S_STATUS;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_STATUS: begin
                    if (cnt == 12'd1) begin
                        state <= S_DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NAND bus outputs decoded from state so an asynchronous reset releases them at once
    always_comb begin
        ce          = 1'b1;
        cle         = 1'b0;
        ale         = 1'b0;
        io_drive_en = 1'b0;
        io_out      = 8'h00;
        we          = 1'b1;
        re          = 1'b1;
        case (state)
            S_CMD1: begin
                ce          = 1'b0;
                cle         = 1'b1;
                io_drive_en = 1'b1;
                io_out      = is_r ? NAND_READ1 : NAND_RDID;
                we          = strobe_n;
            end
            S_ADDR: begin
                ce          = 1'b0;
                ale         = 1'b1;
                io_drive_en = 1'b1;
                io_out      = addr_b[cnt[2:0]];
                we          = strobe_n;
            end
            S_CMD2: begin
                ce          = 1'b0;
                cle         = 1'b1;
                io_drive_en = 1'b1;
                io_out      = NAND_READ2;
                we          = strobe_n;
            end
            S_WAIT: ce = 1'b0;
            S_READ: begin
                ce = 1'b0;
                re = strobe_n;
            end
            default: ;
        endcase
    end

    // RAM port: reads only while fetching, one write per received byte, two status writes
    always_comb begin
        ram_addr  = '0;
        ram_r_e   = 1'b0;
        ram_w_e   = 1'b0;
        ram_wdata = 8'h00;
        done      = (state == S_DONE);
        case (state)
            S_FETCH: begin
                if (cnt < 12'd6) begin
                    ram_addr = ADDR_W'(cnt);
                    ram_r_e  = 1'b1;
                end
            end
            S_READ: begin
                ram_addr  = ADDR_W'(OFS_DATA) + ADDR_W'(cnt);
                ram_w_e   = t_rise;
                ram_wdata = t_rise ? sample_q : 8'h00;
            end
            S_STATUS: begin
                ram_addr  = ADDR_W'(OFS_STAT) + ADDR_W'(cnt);
                ram_w_e   = 1'b1;
                ram_wdata = (cnt == 12'd0) ? status : 8'h00;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_nand_page_sequencer.sv
// Directed bench for nand_page_sequencer with a RAM model, a NAND target
// model and a bus protocol monitor.
module tb_nand_page_sequencer;

    localparam int T_PULSE    = 2;
    localparam int T_WB       = 16;
    localparam int RB_TIMEOUT = 200;
    localparam int PAGE_BYTES = 2112;
    localparam int ADDR_W     = 12;
    localparam int RB_LOW     = 50;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              start = 1'b0;
    logic              done;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_r_e;
    logic              ram_w_e;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata = 8'h00;
    logic              ce, we, re, cle, ale;
    logic              rb = 1'b1;
    logic [7:0]        io_in = 8'h00;
    logic [7:0]        io_out;
    logic              io_drive_en;
    logic [3:0]        state_dbg;

    nand_page_sequencer #(
        .T_PULSE    (T_PULSE),
        .T_WB       (T_WB),
        .RB_TIMEOUT (RB_TIMEOUT),
        .PAGE_BYTES (PAGE_BYTES),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .done        (done),
        .ram_addr    (ram_addr),
        .ram_r_e     (ram_r_e),
        .ram_w_e     (ram_w_e),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .ce          (ce),
        .we          (we),
        .re          (re),
        .cle         (cle),
        .ale         (ale),
        .rb          (rb),
        .io_in       (io_in),
        .io_out      (io_out),
        .io_drive_en (io_drive_en),
        .state_dbg   (state_dbg)
    );

    // ---------------- RAM model ----------------
    logic [7:0]        mem [0:4095];
    logic              tb_we = 1'b0;
    logic [ADDR_W-1:0] tb_addr = '0;
    logic [7:0]        tb_data = 8'h00;

    always @(posedge clk) begin
        if (ram_w_e) mem[ram_addr] <= ram_wdata;
        if (tb_we)   mem[tb_addr]  <= tb_data;
        if (ram_r_e) ram_rdata     <= mem[ram_addr];
    end

    // ---------------- NAND model + protocol monitor ----------------
    logic        clr = 1'b0;
    logic        hold_low = 1'b0;
    logic        mode_id = 1'b0;
    logic [7:0]  data_off = 8'h00;
    logic [7:0]  id_bytes [0:4] = '{8'hEC, 8'hF1, 8'h00, 8'h95, 8'h40};

    logic [9:0]  bus_log [$];
    int          stab_errs = 0;
    int          both_low_errs = 0;
    int          rw_errs = 0;
    int          re_w_errs = 0;
    int          re_pulses = 0;
    int          re_low = 0;
    int          busy_cnt = 0;
    int          k = 0;
    logic        seen30 = 1'b0;
    logic        ce_low_seen = 1'b0;
    logic        ce_at_done = 1'b0;
    logic        prev_we = 1'b1, prev_re = 1'b1, prev_ce = 1'b1, prev_done = 1'b0;
    logic [10:0] prev_bus = '0;

    always @(posedge clk) begin
        #1;
        if (clr) begin
            bus_log.delete();
            ce_low_seen = 1'b0;
            ce_at_done  = 1'b0;
            seen30      = 1'b0;
        end
        if (busy_cnt > 0) busy_cnt--;
        if (rst) begin
            if (!we && !re) both_low_errs++;
            if (ram_w_e && ram_r_e) rw_errs++;
            if (!ce) ce_low_seen = 1'b1;
            if (done && !prev_done) ce_at_done = prev_ce;
            if (!prev_we && we) begin
                if ({cle, ale, io_drive_en, io_out} != prev_bus) stab_errs++;
                bus_log.push_back({cle, ale, io_out});
                if (cle && io_out == 8'h30) begin
                    busy_cnt = RB_LOW;
                    seen30   = 1'b1;
                end
                if (cle && (io_out == 8'h00 || io_out == 8'h90)) k = 0;
            end
            if (prev_re && !re) begin
                re_low = 0;
                io_in  = mode_id ? id_bytes[k % 5] : 8'(k) + data_off;
            end
            if (!re) re_low++;
            if (!prev_re && re) begin
                if (re_low != T_PULSE) re_w_errs++;
                re_pulses++;
                k++;
            end
        end else begin
            re_low = 0;
        end
        rb        = !((busy_cnt > 0) || (hold_low && seen30));
        prev_we   = we;
        prev_re   = re;
        prev_ce   = ce;
        prev_done = done;
        prev_bus  = {cle, ale, io_drive_en, io_out};
    end

    // ---------------- scoreboard ----------------
    int         vectors = 0;
    int         miscompares = 0;
    logic [9:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_log();
        chk("bus_len", bus_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < bus_log.size(); i++) begin
            chk("bus_evt", {22'd0, bus_log[i]}, {22'd0, exp_q[i]});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic ram_put(input int addr, input logic [7:0] data);
        tb_we   = 1'b1;
        tb_addr = ADDR_W'(addr);
        tb_data = data;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic clear_flags();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic wait_done(input int budget, output logic ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            n++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic finish_cmd();
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic load_page_frame();
        ram_put(0, 8'h52);
        for (int i = 1; i <= 5; i++) ram_put(i, 8'(i));
        ram_put(6, 8'hFF);
        ram_put(7, 8'hFF);
    endtask

    task automatic exp_page_log();
        exp_q.delete();
        exp_q.push_back({2'b10, 8'h00});
        for (int i = 1; i <= 5; i++) exp_q.push_back({2'b01, 8'(i)});
        exp_q.push_back({2'b10, 8'h30});
    endtask

    task automatic check_page(input logic [7:0] off);
        for (int i = 0; i < PAGE_BYTES; i++) begin
            chk("page_byte", {24'd0, mem[8 + i]}, {24'd0, 8'(i) + off});
        end
        chk("page_stat", {24'd0, mem[6]}, 32'h00);
        chk("page_b7", {24'd0, mem[7]}, 32'h00);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        logic ok;
        int   n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ce", ce, 1);
        chk("rst_we", we, 1);
        chk("rst_re", re, 1);
        chk("rst_cle", cle, 0);
        chk("rst_ale", ale, 0);
        chk("rst_drv", io_drive_en, 0);
        chk("rst_io", io_out, 0);
        chk("rst_done", done, 0);
        chk("rst_rwe", {ram_r_e, ram_w_e}, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_wdata", ram_wdata, 0);
        rst = 1'b1;
        @(negedge clk);

        // Page read
        load_page_frame();
        clear_flags();
        data_off = 8'h00;
        start = 1'b1;
        wait_done(20000, ok, n);
        chk("page_done", ok, 1);
        exp_page_log();
        check_log();
        check_page(8'h00);
        repeat (4) @(negedge clk);
        chk("done_hold", done, 1);
        start = 1'b0;
        @(negedge clk);
        chk("done_drop", done, 0);
        repeat (2) @(negedge clk);

        // Read ID
        ram_put(0, 8'h49);
        ram_put(1, 8'h00);
        ram_put(6, 8'hFF);
        ram_put(7, 8'hFF);
        clear_flags();
        mode_id = 1'b1;
        start = 1'b1;
        wait_done(2000, ok, n);
        chk("id_done", ok, 1);
        exp_q.delete();
        exp_q.push_back({2'b10, 8'h90});
        exp_q.push_back({2'b01, 8'h00});
        check_log();
        for (int i = 0; i < 5; i++) chk("id_byte", {24'd0, mem[8 + i]}, {24'd0, id_bytes[i]});
        chk("id_no_extra", {24'd0, mem[13]}, 32'h05);
        chk("id_stat", {24'd0, mem[6]}, 32'h00);
        chk("id_b7", {24'd0, mem[7]}, 32'h00);
        finish_cmd();
        mode_id = 1'b0;

        // Bad opcode
        ram_put(0, 8'h41);
        ram_put(7, 8'hFF);
        clear_flags();
        start = 1'b1;
        wait_done(50, ok, n);
        chk("bad_done", ok, 1);
        chk("bad_latency", (n <= 12), 1);
        chk("bad_ce_idle", ce_low_seen, 0);
        chk("bad_stat", {24'd0, mem[6]}, 32'h01);
        chk("bad_b7", {24'd0, mem[7]}, 32'h00);
        chk("bad_log", bus_log.size(), 0);
        finish_cmd();

        // rb timeout
        load_page_frame();
        for (int i = 8; i < 16; i++) ram_put(i, 8'hA5);
        clear_flags();
        hold_low = 1'b1;
        start = 1'b1;
        wait_done(3000, ok, n);
        chk("to_done", ok, 1);
        chk("to_stat", {24'd0, mem[6]}, 32'h02);
        chk("to_b7", {24'd0, mem[7]}, 32'h00);
        for (int i = 8; i < 16; i++) chk("to_untouched", {24'd0, mem[i]}, 32'hA5);
        chk("to_ce_before_done", ce_at_done, 1);
        finish_cmd();
        hold_low = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of a page read
        load_page_frame();
        clear_flags();
        start = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (ram_w_e && ram_addr == ADDR_W'(108)) begin
                ok = 1'b1;
                break;
            end
        end
        chk("mid_reached", ok, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_ce", ce, 1);
        chk("arst_we", we, 1);
        chk("arst_re", re, 1);
        chk("arst_done", done, 0);
        chk("arst_rwe", ram_w_e, 0);
        chk("arst_drv", io_drive_en, 0);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("arst_idle_ce", ce, 1);

        // Recovery page read with a different data pattern
        load_page_frame();
        clear_flags();
        data_off = 8'h3C;
        start = 1'b1;
        wait_done(20000, ok, n);
        chk("rec_done", ok, 1);
        exp_page_log();
        check_log();
        check_page(8'h3C);
        finish_cmd();

        // Protocol monitor results across all tests
        chk("we_stable", stab_errs, 0);
        chk("we_re_overlap", both_low_errs, 0);
        chk("ram_rw_overlap", rw_errs, 0);
        chk("re_width", re_w_errs, 0);
        chk("re_seen", (re_pulses > 2 * PAGE_BYTES), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
